escritor_quadro: RTL and testbench
==================================

Name: escritor_quadro

Overview:
Frame writer at the consuming end of the zoom pipeline's pixel stream. It accepts scaled pixels in row-major order over a valid/ready handshake and tracks column and row position. It issues one registered write per pixel into the output frame buffer at base_addr + linear index, and pulses done on the last pixel of the frame.
Frame dimensions are latched at start, and a configuration change aborts the frame.

Parameters:
DATA_W, 8, pixel width in bits
DIM_W, 10, width of the largura/altura dimensions and of the counters
ADDR_W, 17, frame-buffer address width (320x240 = 76800 words fits)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a frame; sampled only in OCIOSO
config_mudou  input  1  zoom/config change; aborts the frame, priority over everything except reset
largura_max  input  DIM_W  frame width in pixels; latched at start
altura_max  input  DIM_W  frame height in lines; latched at start
base_addr  input  ADDR_W  frame-buffer base; latched at start
pix_valid  input  1  upstream pixel valid
pix_data  input  DATA_W  upstream pixel
pix_ready  output  1  writer accepts a pixel this cycle
mem_busy  input  1  memory cannot take a write in the next cycle
mem_wr_en  output  1  write strobe, one cycle per pixel
mem_addr  output  ADDR_W  write address
mem_data  output  DATA_W  write data
cont_coluna  output  DIM_W  column of the next pixel to be accepted
cont_linha  output  DIM_W  line of the next pixel to be accepted
ocupado  output  1  high while in ESCREVENDO
done  output  1  one-cycle pulse, coincident with the last pixel's mem_wr_en
erro_config  output  1  one-cycle pulse when start is seen with a zero dimension

Behaviour:
- Reset values: state OCIOSO; all outputs 0; latched dimensions, base and running address 0.
- FSM has two states, OCIOSO and ESCREVENDO.
- OCIOSO:
  - start with largura_max != 0 and altura_max != 0: latch dimensions and base, running address <= base_addr, counters <= 0, go to ESCREVENDO.
  - start with either dimension 0: erro_config = 1 for one cycle, stay in OCIOSO.
- ESCREVENDO:
  - ocupado = 1.
  - pix_ready = !mem_busy (combinational); pix_ready is 0 in OCIOSO.
- Accept = pix_valid && pix_ready. On accept, the next cycle drives:
  - mem_wr_en = 1;
  - mem_addr = running address;
  - mem_data = pix_data.
  - Latency is exactly 1 cycle. The running address increments by 1 per accept (no multiplier) and wraps modulo 2^ADDR_W.
- Counter advance on accept:
  - cont_coluna increments; at latched largura-1 it wraps to 0 and cont_linha increments.
  - On the last pixel (coluna = largura-1 and linha = altura-1): counters go to 0 and state returns to OCIOSO.
  - On the following cycle, done = 1 together with the final mem_wr_en.
- No accept: counters, address and state hold; mem_wr_en = 0.
- mem_busy: only gates new accepts. A write already registered is always presented in its cycle.
- config_mudou in ESCREVENDO:
  - State goes to OCIOSO and counters and address clear.
  - A pixel offered in the same cycle is not accepted (pix_ready is forced 0 that cycle).
  - A write registered in the previous cycle is still presented; done is not pulsed.
- config_mudou in OCIOSO: clears counters; start in the same cycle is ignored.
- start while in ESCREVENDO: ignored. Input dimension changes mid-frame are ignored (latched values are used).
- 1x1 frame: a single accept returns the FSM to OCIOSO, and done pulses with that write.
- Reset mid-frame: everything returns to reset values on the next edge, including a pending mem_wr_en.

Test Plan:
1. 4x3 frame, base=100, pix_valid held high with data 0..11 -> 12 consecutive writes at addr 100..111 with data 0..11; done high only with addr 111; ocupado falls the same cycle.
2. 4x2 frame, mem_busy high for 3 cycles after the 2nd accept -> pix_ready low for exactly those 3 cycles; no gaps or duplicates in addr 0..7; counter sequence col 0..3, line 0..1.
3. largura=0 with start -> erro_config pulses once, state stays OCIOSO, pix_ready stays 0, no mem_wr_en.
4. config_mudou asserted mid-frame together with pix_valid -> that pixel is not accepted; no further writes; counters 0; done never pulses; a new start then begins again at base_addr.
5. 1x1 frame, base = 2^17-1, followed by a 2x1 frame at the same base -> single write at 131071 with done; the second frame writes 131071 then 0 (wrap).
6. Reset asserted the cycle after an accept -> mem_wr_en 0 on the next edge; all outputs equal their reset values.

Source files
------------

// File: rtl/escritor_quadro_if.sv
// Pixel-stream and frame-buffer write bus of the frame writer.
//   pix_valid / pix_data / pix_ready : upstream pixel handshake
//   mem_busy                         : memory back-pressure
//   mem_wr_en / mem_addr / mem_data  : registered frame-buffer write
// master = pixel source and memory side, slave = the frame writer.
interface escritor_quadro_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 17
);
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_ready;
    logic              mem_busy;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output pix_valid, pix_data, mem_busy,
        input  pix_ready, mem_wr_en, mem_addr, mem_data
    );

    modport slave (
        input  pix_valid, pix_data, mem_busy,
        output pix_ready, mem_wr_en, mem_addr, mem_data
    );
endinterface

// File: rtl/escritor_quadro.sv
// Frame writer: accepts row-major scaled pixels and writes each one to the
// frame buffer at base + linear index, one cycle after the accept.
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   start, config_mudou  : begin a frame / abort the current frame
//   largura_max, altura_max, base_addr : frame geometry, latched at start
//   bus (slave)          : pixel handshake and frame-buffer write port
//   cont_coluna, cont_linha : position of the next pixel to be accepted
//   ocupado              : frame in progress
//   done                 : pulses with the write of the last pixel
//   erro_config          : pulses after a start with a zero dimension
module escritor_quadro #(
    parameter int DATA_W = 8,
    parameter int DIM_W  = 10,
    parameter int ADDR_W = 17
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     config_mudou,
    input  logic [DIM_W-1:0]         largura_max,
    input  logic [DIM_W-1:0]         altura_max,
    input  logic [ADDR_W-1:0]        base_addr,
    escritor_quadro_if.slave         bus,
    output logic [DIM_W-1:0]         cont_coluna,
    output logic [DIM_W-1:0]         cont_linha,
    output logic                     ocupado,
    output logic                     done,
    output logic                     erro_config
);
    typedef enum logic {OCIOSO = 1'b0, ESCREVENDO = 1'b1} estado_t;

    estado_t           estado_q, estado_d;
    logic [DIM_W-1:0]  larg_q, larg_d, alt_q, alt_d;
    logic [DIM_W-1:0]  col_q, col_d, lin_q, lin_d;
    // Running address starts at the latched base and steps by one per
    // accepted pixel, so no row * width multiply is ever needed.
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              done_q, done_d;
    logic              erro_q, erro_d;
    logic              pix_ready_c;

    always_comb begin
        estado_d    = estado_q;
        larg_d      = larg_q;
        alt_d       = alt_q;
        col_d       = col_q;
        lin_d       = lin_q;
        addr_d      = addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        done_d      = 1'b0;
        erro_d      = 1'b0;
        pix_ready_c = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (config_mudou) begin
                    col_d  = '0;
                    lin_d  = '0;
                    addr_d = '0;
                end else if (start) begin
                    if (largura_max != '0 && altura_max != '0) begin
                        larg_d   = largura_max;
                        alt_d    = altura_max;
                        addr_d   = base_addr;
                        col_d    = '0;
                        lin_d    = '0;
                        estado_d = ESCREVENDO;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            ESCREVENDO: begin
                if (config_mudou) begin
                    // Abort: the pixel offered now is refused; a write
                    // registered last cycle still goes out (wr_en_q).
                    estado_d = OCIOSO;
                    col_d    = '0;
                    lin_d    = '0;
                    addr_d   = '0;
                end else begin
                    pix_ready_c = !bus.mem_busy;
                    if (bus.pix_valid && pix_ready_c) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = bus.pix_data;
                        addr_d    = addr_q + 1'b1;
                        if (col_q == DIM_W'(larg_q - 1'b1)) begin
                            col_d = '0;
                            if (lin_q == DIM_W'(alt_q - 1'b1)) begin
                                lin_d    = '0;
                                estado_d = OCIOSO;
                                done_d   = 1'b1;
                            end else begin
                                lin_d = lin_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            larg_q    <= '0;
            alt_q     <= '0;
            col_q     <= '0;
            lin_q     <= '0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            larg_q    <= larg_d;
            alt_q     <= alt_d;
            col_q     <= col_d;
            lin_q     <= lin_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            erro_q    <= erro_d;
        end
    end

    assign bus.pix_ready = pix_ready_c;
    assign bus.mem_wr_en = wr_en_q;
    assign bus.mem_addr  = wr_addr_q;
    assign bus.mem_data  = wr_data_q;
    assign cont_coluna   = col_q;
    assign cont_linha    = lin_q;
    assign ocupado       = (estado_q == ESCREVENDO);
    assign done          = done_q;
    assign erro_config   = erro_q;
endmodule

// File: tb/tb_escritor_quadro.sv
// Randomized scoreboard bench for escritor_quadro: the stimulus side keeps a
// frame-level model (pixel count, geometry) and queues expected writes; a
// separate monitor pops and compares whenever mem_wr_en is seen.
module tb_escritor_quadro;
    localparam int DATA_W = 8;
    localparam int DIM_W  = 10;
    localparam int ADDR_W = 17;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              config_mudou;
    logic [DIM_W-1:0]  largura_max;
    logic [DIM_W-1:0]  altura_max;
    logic [ADDR_W-1:0] base_addr;
    logic [DIM_W-1:0]  cont_coluna;
    logic [DIM_W-1:0]  cont_linha;
    logic              ocupado;
    logic              done;
    logic              erro_config;

    escritor_quadro_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    escritor_quadro #(.DATA_W(DATA_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .config_mudou (config_mudou),
        .largura_max  (largura_max),
        .altura_max   (altura_max),
        .base_addr    (base_addr),
        .bus          (bus.slave),
        .cont_coluna  (cont_coluna),
        .cont_linha   (cont_linha),
        .ocupado      (ocupado),
        .done         (done),
        .erro_config  (erro_config)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Frame-level reference model.
    bit                in_frame = 1'b0;
    int                m_w = 1;
    int                m_h = 1;
    logic [ADDR_W-1:0] m_base = '0;
    int                n = 0;
    bit                erro_exp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    // Monitor: every presented write must match the oldest queued expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (bus.mem_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write got addr %0d data %0d want no write",
                         bus.mem_addr, bus.mem_data);
            end else begin
                e = sb.pop_front();
                $display("WR addr %0d data %0d done %0b", bus.mem_addr, bus.mem_data, done);
                chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                chk("wr_data", 32'(bus.mem_data), 32'(e.data));
                chk("wr_done", 32'(done), 32'(e.last));
            end
        end else begin
            chk("done_without_write", 32'(done), 32'd0);
        end
    end

    // One clock cycle: check combinational/state outputs against the model,
    // advance the model, and queue the write caused by this cycle's accept.
    task automatic step();
        bit   exp_ready;
        bit   acc;
        bit   erro_next;
        exp_t e;
        @(negedge clock);
        exp_ready = in_frame && !bus.mem_busy && !config_mudou;
        acc       = !reset && bus.pix_valid && exp_ready;
        chk("pix_ready", 32'(bus.pix_ready), 32'(exp_ready));
        chk("ocupado", 32'(ocupado), 32'(in_frame));
        chk("cont_coluna", 32'(cont_coluna), in_frame ? 32'(n % m_w) : 32'd0);
        chk("cont_linha", 32'(cont_linha), in_frame ? 32'(n / m_w) : 32'd0);
        chk("erro_config", 32'(erro_config), 32'(erro_exp));
        erro_next = 1'b0;
        if (reset) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (start && !config_mudou) begin
                if (largura_max != '0 && altura_max != '0) begin
                    in_frame = 1'b1;
                    m_w      = int'(largura_max);
                    m_h      = int'(altura_max);
                    m_base   = base_addr;
                    n        = 0;
                end else begin
                    erro_next = 1'b1;
                end
            end
        end else if (config_mudou) begin
            in_frame = 1'b0;
        end else if (acc) begin
            e.addr = m_base + ADDR_W'(n);
            e.data = bus.pix_data;
            e.last = (n == m_w * m_h - 1);
            n++;
            if (n == m_w * m_h) in_frame = 1'b0;
        end
        @(posedge clock);
        if (acc) sb.push_back(e);
        erro_exp = erro_next;
        #1;
    endtask

    task automatic idle_inputs();
        start        = 1'b0;
        config_mudou = 1'b0;
        bus.pix_valid = 1'b0;
        bus.mem_busy  = 1'b0;
    endtask

    task automatic begin_frame(input int w, input int h, input logic [ADDR_W-1:0] b);
        largura_max   = DIM_W'(w);
        altura_max    = DIM_W'(h);
        base_addr     = b;
        start         = 1'b1;
        bus.pix_valid = 1'b0;
        step();
        start = 1'b0;
    endtask

    // Runs a whole frame with random valid/busy; busy_at >= 0 forces mem_busy
    // for 3 cycles once busy_at pixels have been accepted. Geometry inputs and
    // start are scrambled mid-frame and must be ignored.
    task automatic run_frame(input int w, input int h, input logic [ADDR_W-1:0] b,
                             input int vp, input int bp, input int busy_at);
        int cyc = 0;
        int bc  = 0;
        begin_frame(w, h, b);
        while (in_frame && cyc < 3000) begin
            bus.pix_valid = (int'($urandom_range(99)) < vp);
            bus.pix_data  = DATA_W'($urandom);
            if (busy_at >= 0 && n == busy_at && bc < 3) begin
                bus.mem_busy = 1'b1;
                bc++;
            end else begin
                bus.mem_busy = (int'($urandom_range(99)) < bp);
            end
            largura_max = DIM_W'($urandom);
            altura_max  = DIM_W'($urandom);
            start       = ($urandom_range(7) == 0);
            step();
            cyc++;
        end
        chk("frame_timeout", 32'(in_frame), 32'd0);
        idle_inputs();
        step();
        step();
    endtask

    task automatic check_reset_outputs();
        @(negedge clock);
        chk("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_data", 32'(bus.mem_data), 32'd0);
        chk("rst_ready", 32'(bus.pix_ready), 32'd0);
        chk("rst_col", 32'(cont_coluna), 32'd0);
        chk("rst_lin", 32'(cont_linha), 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_erro", 32'(erro_config), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        bus.pix_data = '0;
        largura_max  = '0;
        altura_max   = '0;
        base_addr    = '0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        step();

        // 4x3 streaming frame at base 100.
        run_frame(4, 3, 17'd100, 100, 0, -1);
        // 4x2 frame with a 3-cycle busy window after the 2nd accept.
        run_frame(4, 2, 17'd0, 100, 0, 2);

        // Zero dimensions raise erro_config and never start a frame.
        begin_frame(0, 5, 17'd7);
        bus.pix_valid = 1'b1;
        repeat (3) step();
        bus.pix_valid = 1'b0;
        begin_frame(3, 0, 17'd7);
        repeat (2) step();

        // Abort mid-frame with a pixel offered in the same cycle.
        begin_frame(4, 3, 17'd500);
        bus.pix_valid = 1'b1;
        repeat (5) begin
            bus.pix_data = DATA_W'($urandom);
            step();
        end
        config_mudou = 1'b1;
        step();
        start = 1'b1;              // ignored: config_mudou still high in OCIOSO
        step();
        idle_inputs();
        bus.pix_valid = 1'b1;
        repeat (4) step();
        idle_inputs();
        run_frame(4, 3, 17'd500, 80, 20, -1);

        // Single-pixel frame at the top address, then a wrapping 2x1 frame.
        run_frame(1, 1, 17'h1FFFF, 100, 0, -1);
        run_frame(2, 1, 17'h1FFFF, 100, 0, -1);

        // Random geometries, bases and back-pressure.
        for (int i = 0; i < 8; i++)
            run_frame(int'($urandom_range(5, 1)), int'($urandom_range(4, 1)),
                      ADDR_W'($urandom), 70, 30, -1);

        // Reset the cycle after an accept.
        begin_frame(3, 3, 17'd40);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'hA5;
        repeat (2) step();
        bus.pix_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_outputs();
        run_frame(2, 2, 17'd40, 100, 0, -1);

        repeat (3) step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
